state_dump_scanner: RTL
=======================

STATE_DUMP_SCANNER -- requirements
Module: state_dump_scanner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of every dumped word.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning the number of register-file entries dumped (1..256).
REQ-003 SHALL have parameter MEM_WORDS, default 32, meaning the number of data-memory words dumped (0..65535); 0 means the memory phase is skipped.
REQ-004 SHALL have parameter MEM_BASE, default 0, meaning the first memory word index dumped.
REQ-005 Port clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-006 Port rst_i  in  1  reset, asynchronous, active-high.
REQ-007 Port trig_i  in  1  a single-cycle pulse that starts a dump.
REQ-008 Port pc_i  in  DATA_WIDTH  the live PC value, snapshotted on an accepted trigger.
REQ-009 Port reg_addr_o  out  clog2(NUM_REGS)  register-file read address; reg_data_i returns the data combinationally.
REQ-010 Port reg_data_i  in  DATA_WIDTH  register-file read data.
REQ-011 Port mem_addr_o  out  16  data-memory word address; mem_data_i is valid one cycle later.
REQ-012 Port mem_data_i  in  DATA_WIDTH  data-memory read data.
REQ-013 Port rec_valid_o / rec_ready_i  out/in  1/1  record stream handshake.
REQ-014 Port rec_kind_o  out  2  record kind: 0 = PC, 1 = REG, 2 = MEM.
REQ-015 Port rec_index_o  out  16  register number or memory word address of the record; 0 for PC.
REQ-016 Port rec_data_o  out  DATA_WIDTH  the record payload.
REQ-017 Ports busy_o, done_o and overrun_o  out  1 each  dump in progress; one-cycle end pulse; sticky lost-trigger flag.

Function
REQ-018 The FSM SHALL have the states IDLE, PC, REG, MEM_REQ, MEM_RSP and DONE.
REQ-019 In IDLE, trig_i=1 SHALL capture pc_i and move the FSM to PC, so the PC record is valid on the next cycle.
REQ-020 The PC, REG and MEM_RSP states SHALL hold rec_valid_o=1; a record is transferred only in a cycle where rec_valid_o=1 and rec_ready_i=1.
REQ-021 While rec_valid_o=1 and rec_ready_i=0, rec_kind_o, rec_index_o and rec_data_o SHALL stay stable.
REQ-022 REG SHALL emit registers 0..NUM_REGS-1 in ascending order, at most one per cycle, with reg_addr_o equal to rec_index_o.
REQ-023 After the last register transfers, the FSM SHALL go to MEM_REQ, or to DONE if MEM_WORDS=0.
REQ-024 MEM_REQ SHALL drive mem_addr_o, and MEM_RSP SHALL register mem_data_i on entry and hold it until it transfers, giving at most one memory record per 2 cycles.
REQ-025 Memory addresses SHALL run from MEM_BASE to MEM_BASE+MEM_WORDS-1 and wrap modulo 2^16.
REQ-026 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-027 busy_o SHALL be 1 in every state except IDLE.
REQ-028 A trig_i=1 while busy_o=1 SHALL be ignored and SHALL set overrun_o, which stays set until reset.
REQ-029 A trig_i=1 in the same cycle that DONE returns to IDLE SHALL be ignored.
REQ-030 The block SHALL emit exactly 1+NUM_REGS+MEM_WORDS records per dump.
REQ-031 Index counters SHALL be sized so that the final compare does not overflow at NUM_REGS=256 or MEM_WORDS=65535.

Reset
REQ-032 rst_i=1 SHALL force IDLE immediately, with no clock required, and clear all counters.
REQ-033 During reset, rec_valid_o, busy_o, done_o and overrun_o SHALL be 0, and rec_kind_o, rec_index_o, rec_data_o, reg_addr_o and mem_addr_o SHALL be 0.
REQ-034 A reset asserted mid-dump SHALL abandon the dump without emitting a done_o pulse.

Structure
REQ-035 The record-kind encodings and the FSM state enumeration SHALL live in the shared package cpu_dbg_pkg.
REQ-036 The record output register and handshake SHALL be one sub-module, dump_rec_reg, holding {kind, index, data} under valid/ready.

Verification
REQ-037 Run with NUM_REGS=4, MEM_WORDS=2, MEM_BASE=5, pc_i=0x40, reg[i]=10+i, mem[5]=7, mem[6]=9, ready held at 1 -> the records are (0,0,0x40), (1,0,10), (1,1,11), (1,2,12), (1,3,13), (2,5,7), (2,6,9), and done_o pulses once.
REQ-038 Same setup with rec_ready_i toggling 1/0 every cycle -> the same 7 records arrive, and the outputs are stable in every stalled cycle.
REQ-039 Pulse trig_i at record 3 of a dump -> the dump is unaffected, overrun_o=1 afterwards, and no second dump starts.
REQ-040 Assert rst_i asynchronously during MEM_RSP -> all outputs are 0 before the next clock edge, with no done_o pulse; a new trigger then produces a complete dump.
REQ-041 Run with MEM_WORDS=0 -> 1+NUM_REGS records are emitted and done_o follows the last register record.
REQ-042 Run with MEM_BASE=0xFFFF and MEM_WORDS=2 -> the memory records are at index 0xFFFF and then 0x0000.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared debug-dump types: record kinds and the scanner FSM states.
// Imported by the state dump scanner and its record register.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    KIND_PC  = 2'd0,
    KIND_REG = 2'd1,
    KIND_MEM = 2'd2
  } rec_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PC,
    ST_REG,
    ST_MEM_REQ,
    ST_MEM_RSP,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/dump_rec_reg.sv
// Record output register: holds {kind, index, data} under valid/ready.
// A bypass lets live read data drive the payload while it is stable.
module dump_rec_reg
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [1:0]            kind_i,
  input  logic [15:0]           index_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  upd_i,
  input  logic [DATA_WIDTH-1:0] upd_data_i,
  input  logic                  byp_i,
  input  logic [DATA_WIDTH-1:0] byp_data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic                  fire_o,
  output logic [1:0]            kind_o,
  output logic [15:0]           index_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q;
  logic [1:0]            kind_q;
  logic [15:0]           index_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign valid_o = valid_q;
  assign fire_o  = valid_q & ready_i;
  assign kind_o  = kind_q;
  assign index_o = index_q;
  assign data_o  = byp_i ? byp_data_i : data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      kind_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      if (load_i) begin
        valid_q <= 1'b1;
        kind_q  <= kind_i;
        index_q <= index_i;
        data_q  <= data_i;
      end else begin
        if (fire_o)
          valid_q <= 1'b0;
        if (upd_i)
          data_q <= upd_data_i;
      end
    end
  end

endmodule

// File: rtl/state_dump_scanner.sv
// Dumps PC, register file and a data-memory window as a record stream.
// One record per cycle for registers, one per two cycles for memory.
module state_dump_scanner
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int MEM_WORDS  = 32,
  parameter int MEM_BASE   = 0,
  localparam int RAW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trig_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic [RAW-1:0]        reg_addr_o,
  input  logic [DATA_WIDTH-1:0] reg_data_i,
  output logic [15:0]           mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  rec_valid_o,
  input  logic                  rec_ready_i,
  output logic [1:0]            rec_kind_o,
  output logic [15:0]           rec_index_o,
  output logic [DATA_WIDTH-1:0] rec_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overrun_o
);

  localparam logic [15:0] MB      = 16'(MEM_BASE);
  localparam logic [8:0]  REG_END = 9'(NUM_REGS - 1);
  localparam logic [16:0] MEM_END = 17'(MEM_WORDS - 1);

  dump_state_e state, nxt;

  logic [8:0]            reg_cnt;
  logic [16:0]           mem_cnt;
  logic [15:0]           mem_addr;
  logic                  rsp_first;
  logic                  overrun_q;
  logic                  fire;
  logic                  load, upd, byp;
  logic                  reg_clr, reg_inc;
  logic                  mem_clr, mem_inc;
  rec_kind_e             ld_kind;
  logic [15:0]           ld_idx;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] byp_data;

  assign mem_addr = MB + mem_cnt[15:0];

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    upd      = 1'b0;
    byp      = 1'b0;
    byp_data = reg_data_i;
    ld_kind  = KIND_REG;
    ld_idx   = '0;
    ld_data  = '0;
    reg_clr  = 1'b0;
    reg_inc  = 1'b0;
    mem_clr  = 1'b0;
    mem_inc  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (trig_i) begin
          load    = 1'b1;
          ld_kind = KIND_PC;
          ld_data = pc_i;
          reg_clr = 1'b1;
          mem_clr = 1'b1;
          nxt     = ST_PC;
        end
      end
      ST_PC: begin
        if (fire) begin
          load = 1'b1;
          nxt  = ST_REG;
        end
      end
      ST_REG: begin
        byp = 1'b1;
        if (fire) begin
          if (reg_cnt == REG_END) begin
            nxt = (MEM_WORDS == 0) ? ST_DONE : ST_MEM_REQ;
          end else begin
            load    = 1'b1;
            ld_idx  = 16'(reg_cnt + 9'd1);
            reg_inc = 1'b1;
          end
        end
      end
      ST_MEM_REQ: begin
        load    = 1'b1;
        ld_kind = KIND_MEM;
        ld_idx  = mem_addr;
        nxt     = ST_MEM_RSP;
      end
      ST_MEM_RSP: begin
        // Read data is only live in the first cycle; capture it then.
        if (rsp_first) begin
          byp      = 1'b1;
          byp_data = mem_data_i;
          upd      = 1'b1;
        end
        if (fire) begin
          mem_inc = 1'b1;
          nxt     = (mem_cnt == MEM_END) ? ST_DONE : ST_MEM_REQ;
        end
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      reg_cnt   <= '0;
      mem_cnt   <= '0;
      rsp_first <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= nxt;
      rsp_first <= (state == ST_MEM_REQ);
      if (reg_clr)
        reg_cnt <= '0;
      else if (reg_inc)
        reg_cnt <= reg_cnt + 9'd1;
      if (mem_clr)
        mem_cnt <= '0;
      else if (mem_inc)
        mem_cnt <= mem_cnt + 17'd1;
      if (trig_i && state != ST_IDLE)
        overrun_q <= 1'b1;
    end
  end

  dump_rec_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rec (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .kind_i     (ld_kind),
    .index_i    (ld_idx),
    .data_i     (ld_data),
    .upd_i      (upd),
    .upd_data_i (mem_data_i),
    .byp_i      (byp),
    .byp_data_i (byp_data),
    .ready_i    (rec_ready_i),
    .valid_o    (rec_valid_o),
    .fire_o     (fire),
    .kind_o     (rec_kind_o),
    .index_o    (rec_index_o),
    .data_o     (rec_data_o)
  );

  assign reg_addr_o = (state == ST_REG) ? reg_cnt[RAW-1:0] : '0;
  assign mem_addr_o = (state == ST_MEM_REQ || state == ST_MEM_RSP)
                    ? mem_addr : '0;
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = (state == ST_DONE);
  assign overrun_o  = overrun_q;

endmodule
